io_line_bridge: RTL and testbench

//  Peripheral on the far side of the processor's 16-bit inputLine/outputLine port.

---
 rtl/io_line_bridge_if.sv | 31 +++
 rtl/io_line_bridge.sv | 137 +++++++++++++
 tb/tb_io_line_bridge.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_line_bridge_if.sv
// Host-side valid/ready channels of the processor line bridge.
// host_in_*  : host -> processor words (into the RX FIFO)
// host_out_* : processor -> host words (out of the TX FIFO)
interface io_line_bridge_if;
    logic [13:0] host_in_data;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [13:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;

    // Host side drives offers and acceptance.
    modport master (
        output host_in_data,
        output host_in_valid,
        input  host_in_ready,
        input  host_out_data,
        input  host_out_valid,
        output host_out_ready
    );

    // Bridge side.
    modport slave (
        input  host_in_data,
        input  host_in_valid,
        output host_in_ready,
        output host_out_data,
        output host_out_valid,
        input  host_out_ready
    );
endinterface

// File: rtl/io_line_bridge.sv
// Bridge between the processor's raw 16-bit inputLine/outputLine port and a
// valid/ready host. outputLine carries toggle-encoded push (bit 14) and ack
// (bit 15) events; each direction is buffered by a DEPTH-entry FIFO.
module io_line_bridge #(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       outputLine,
    output logic [15:0]       inputLine,
    io_line_bridge_if.slave   host,
    output logic              tx_overflow,
    output logic              rx_underflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [15:0]   s;
    logic [15:0]   p;
    logic [1:0]    prime;
    logic          armed;
    logic          tx_evt;
    logic          ack_evt;

    logic [13:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wr;
    logic [AW-1:0] tx_rd;
    logic [CW-1:0] tx_cnt;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_push;
    logic          tx_pop;

    logic [13:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wr;
    logic [AW-1:0] rx_rd;
    logic [CW-1:0] rx_cnt;
    logic          rx_full;
    logic          rx_empty;
    logic          rx_push;
    logic          rx_pop;

    // The first two post-reset samples may hold arbitrary power-up levels,
    // so toggle detection only starts once both s and p hold real samples.
    assign armed   = (prime == 2'd2);
    assign tx_evt  = armed & (s[14] ^ p[14]);
    assign ack_evt = armed & (s[15] ^ p[15]);

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    // Full/empty are judged on pre-edge counts, so a full FIFO drops a
    // simultaneous push even while it pops.
    assign tx_push = tx_evt & ~tx_full;
    assign tx_pop  = host.host_out_ready & ~tx_empty;
    assign rx_push = host.host_in_valid & ~rx_full;
    assign rx_pop  = ack_evt & ~rx_empty;

    assign host.host_out_valid = ~tx_empty;
    assign host.host_out_data  = tx_mem[tx_rd];
    assign host.host_in_ready  = ~rx_full;
    assign inputLine = {~rx_empty, tx_full, rx_empty ? 14'h0000 : rx_mem[rx_rd]};

    // Two-stage sample of the processor line plus the arming counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            p     <= '0;
            prime <= '0;
        end else begin
            s <= outputLine;
            p <= s;
            if (!armed) begin
                prime <= prime + 2'd1;
            end
        end
    end

    // TX FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_cnt      <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr <= tx_wr + AW'(1);
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + AW'(1);
            end
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            if (tx_evt && tx_full) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // TX FIFO storage; the word pushed is the sample that carried the toggle.
    always_ff @(posedge clk) begin
        if (!rst && tx_push) begin
            tx_mem[tx_wr] <= s[13:0];
        end
    end

    // RX FIFO pointers, occupancy and underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr        <= '0;
            rx_rd        <= '0;
            rx_cnt       <= '0;
            rx_underflow <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wr <= rx_wr + AW'(1);
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + AW'(1);
            end
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            if (ack_evt && rx_empty) begin
                rx_underflow <= 1'b1;
            end
        end
    end

    // RX FIFO storage written from the host channel.
    always_ff @(posedge clk) begin
        if (!rst && rx_push) begin
            rx_mem[rx_wr] <= host.host_in_data;
        end
    end
endmodule

// File: tb/tb_io_line_bridge.sv
// Directed bench for io_line_bridge: a queue-level model of both FIFOs and
// the toggle protocol is checked every cycle, plus literal expectations.
module tb_io_line_bridge;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [15:0] outputLine;
    logic [15:0] inputLine;
    logic        tx_overflow;
    logic        rx_underflow;

    io_line_bridge_if hif ();

    io_line_bridge #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .outputLine   (outputLine),
        .inputLine    (inputLine),
        .host         (hif.slave),
        .tx_overflow  (tx_overflow),
        .rx_underflow (rx_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words queued in each direction, every line value seen at an edge
    // since reset, and the sticky flags.
    logic [13:0] tq[$];
    logic [13:0] rq[$];
    logic [15:0] seen[$];
    logic        m_txo;
    logic        m_rxu;
    logic        live = 1'b0;

    // A toggle between two consecutive line samples (never the very first
    // sample after reset) is acted upon one edge after it is observed.
    always @(posedge clk) begin : model
        automatic bit          tev = 0;
        automatic bit          aev = 0;
        automatic int          tn  = tq.size();
        automatic int          rn  = rq.size();
        automatic logic [15:0] a;
        automatic logic [15:0] b;
        if (rst) begin
            tq.delete();
            rq.delete();
            seen.delete();
            m_txo <= 1'b0;
            m_rxu <= 1'b0;
            live  <= 1'b1;
        end else begin
            a = 16'h0000;
            if (seen.size() >= 2) begin
                a   = seen[seen.size()-1];
                b   = seen[seen.size()-2];
                tev = (a[14] != b[14]);
                aev = (a[15] != b[15]);
            end
            seen.push_back(outputLine);
            if (hif.host_out_ready && tn > 0) void'(tq.pop_front());
            if (tev) begin
                if (tn < DEPTH) tq.push_back(a[13:0]);
                else m_txo <= 1'b1;
            end
            if (aev) begin
                if (rn > 0) void'(rq.pop_front());
                else m_rxu <= 1'b1;
            end
            if (hif.host_in_valid && rn < DEPTH) rq.push_back(hif.host_in_data);
        end
    end

    // Compare all DUT outputs against the model on every falling edge.
    always @(negedge clk) begin : compare
        automatic logic [15:0] exp_line;
        if (live) begin
            exp_line = {(rq.size() > 0), (tq.size() == DEPTH), 14'h0000};
            if (rq.size() > 0) exp_line[13:0] = rq[0];
            check("m_inputLine", inputLine, exp_line);
            check("m_out_valid", {15'h0, hif.host_out_valid}, {15'h0, (tq.size() > 0)});
            check("m_in_ready", {15'h0, hif.host_in_ready}, {15'h0, (rq.size() < DEPTH)});
            check("m_tx_overflow", {15'h0, tx_overflow}, {15'h0, m_txo});
            check("m_rx_underflow", {15'h0, rx_underflow}, {15'h0, m_rxu});
            if (tq.size() > 0) check("m_out_data", {2'b00, hif.host_out_data}, {2'b00, tq[0]});
        end
    end

    logic txb;
    logic ackb;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tx_toggle(input logic [13:0] d);
        txb = ~txb;
        outputLine = {ackb, txb, d};
    endtask

    task automatic ack_toggle();
        ackb = ~ackb;
        outputLine[15] = ackb;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int tx_sent;
        int tx_got;
        int rx_sent;
        int rx_acks;
        int cyc;
        bit pending;

        rst = 1'b1;
        outputLine = 16'hC000;
        txb = 1'b1;
        ackb = 1'b1;
        hif.host_in_data = 14'h0000;
        hif.host_in_valid = 1'b0;
        hif.host_out_ready = 1'b0;

        // 1: power-up level held through reset and release is not a toggle.
        repeat (2) tick();
        check("t1_rst_line", inputLine, 16'h0000);
        check("t1_rst_ready", {15'h0, hif.host_in_ready}, 16'h0001);
        rst = 1'b0;
        repeat (4) tick();
        check("t1_line", inputLine, 16'h0000);
        check("t1_valid", {15'h0, hif.host_out_valid}, 16'h0000);
        check("t1_flags", {14'h0, tx_overflow, rx_underflow}, 16'h0000);

        // 2: single TX word, latency N+1, then popped.
        tx_toggle(14'h1234);
        tick();
        check("t2_not_yet", {15'h0, hif.host_out_valid}, 16'h0000);
        tick();
        check("t2_valid", {15'h0, hif.host_out_valid}, 16'h0001);
        check("t2_data", {2'b00, hif.host_out_data}, 16'h1234);
        hif.host_out_ready = 1'b1;
        tick();
        hif.host_out_ready = 1'b0;
        check("t2_drained", {15'h0, hif.host_out_valid}, 16'h0000);

        // 3: nine back-to-back toggles into an 8-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            tx_toggle(14'h0100 + 14'(i));
            tick();
        end
        repeat (2) tick();
        check("t3_full_bit", {15'h0, inputLine[14]}, 16'h0001);
        check("t3_overflow", {15'h0, tx_overflow}, 16'h0001);
        hif.host_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_order", {2'b00, hif.host_out_data}, 16'h0100 + 16'(i));
            tick();
        end
        hif.host_out_ready = 1'b0;
        check("t3_ninth_absent", {15'h0, hif.host_out_valid}, 16'h0000);

        // Reset mid-operation discards buffered words in both FIFOs.
        tx_toggle(14'h0555);
        hif.host_in_data = 14'h0666;
        hif.host_in_valid = 1'b1;
        tick();
        hif.host_in_valid = 1'b0;
        repeat (2) tick();
        check("mr_tx_held", {15'h0, hif.host_out_valid}, 16'h0001);
        check("mr_rx_held", inputLine, 16'h8666);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_line", inputLine, 16'h0000);
        check("mr_valid", {15'h0, hif.host_out_valid}, 16'h0000);
        check("mr_flags", {14'h0, tx_overflow, rx_underflow}, 16'h0000);
        repeat (3) tick();

        // 4: host word into empty RX, then acked.
        hif.host_in_data = 14'h0ABC;
        hif.host_in_valid = 1'b1;
        tick();
        hif.host_in_valid = 1'b0;
        check("t4_visible", inputLine, 16'h8ABC);
        ack_toggle();
        tick();
        check("t4_still", inputLine, 16'h8ABC);
        tick();
        check("t4_popped", inputLine, 16'h0000);

        // 5: ack on empty, then full RX with held offer plus ack.
        ack_toggle();
        repeat (2) tick();
        check("t5_underflow", {15'h0, rx_underflow}, 16'h0001);
        check("t5_empty", inputLine, 16'h0000);
        hif.host_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hif.host_in_data = 14'h0200 + 14'(i);
            tick();
        end
        hif.host_in_data = 14'h02FF;
        check("t5_not_ready", {15'h0, hif.host_in_ready}, 16'h0000);
        ack_toggle();
        repeat (2) tick();
        hif.host_in_valid = 1'b0;
        check("t5_one_pop", inputLine, 16'h8201);
        check("t5_ready", {15'h0, hif.host_in_ready}, 16'h0001);
        for (int i = 1; i < 8; i++) begin
            check("t5_drain", inputLine, 16'h8200 + 16'(i));
            ack_toggle();
            repeat (2) tick();
        end
        check("t5_count7", inputLine, 16'h0000);
        check("t5_sticky", {15'h0, rx_underflow}, 16'h0001);

        // 6: 20 words each way with random gaps.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        tx_sent = 0;
        tx_got = 0;
        rx_sent = 0;
        rx_acks = 0;
        cyc = 0;
        pending = 1'b0;
        while ((tx_got < 20 || rx_acks < 20) && cyc < 2000) begin
            hif.host_out_ready = 1'($urandom_range(0, 1));
            if (hif.host_out_valid && hif.host_out_ready) begin
                check("t6_tx_order", {2'b00, hif.host_out_data}, 16'h0300 + 16'(tx_got));
                tx_got++;
            end
            if (tx_sent < 20 && (tx_sent - tx_got) < 6 && $urandom_range(0, 2) != 0) begin
                tx_toggle(14'h0300 + 14'(tx_sent));
                tx_sent++;
            end
            if (pending) begin
                rx_sent++;
                pending = 1'b0;
            end
            if (rx_sent < 20) begin
                hif.host_in_valid = 1'($urandom_range(0, 1));
                hif.host_in_data = 14'h0400 + 14'(rx_sent);
                pending = hif.host_in_valid && hif.host_in_ready;
            end else begin
                hif.host_in_valid = 1'b0;
            end
            if (rx_sent > rx_acks && $urandom_range(0, 2) != 0) begin
                ack_toggle();
                rx_acks++;
            end
            tick();
            cyc++;
        end
        hif.host_out_ready = 1'b0;
        hif.host_in_valid = 1'b0;
        check("t6_tx_count", 16'(tx_got), 16'd20);
        check("t6_rx_acks", 16'(rx_acks), 16'd20);
        repeat (3) tick();
        check("t6_rx_empty", inputLine, 16'h0000);
        check("t6_tx_empty", {15'h0, hif.host_out_valid}, 16'h0000);
        check("t6_flags", {14'h0, tx_overflow, rx_underflow}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
